// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: requester ids, access
// size encodings and the layout of one order-FIFO entry.
package sram_bus_arbiter_pkg;

  typedef enum logic {
    ID_I = 1'b0,
    ID_D = 1'b1
  } master_id_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int FIFO_ENTRY_W = 2;

  typedef struct packed {
    master_id_t id;
    logic       discard;
  } order_entry_t;

endpackage

// File: rtl/sram_bus_arbiter_order_fifo.sv
// In-order record of accepted transactions: each entry remembers which
// requester issued it and whether its response must be thrown away.
// A cancel marks every stored fetch entry as discarded in one cycle.
module arb_order_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  order_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       cancel_i,
  output order_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  order_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;

  // Storage, pointers and occupancy; a push overrides a cancel mark on its own slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '{id: ID_I, discard: 1'b0};
      end
    end else begin
      if (cancel_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (mem[k].id == ID_I) begin
            mem[k].discard <= 1'b1;
          end
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction fetch (I) and
// load/store (D), routing responses back in issue order and dropping fetch
// responses after a flush.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants between the two
// requesters when both ask at once; otherwise D always beats I.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      i_req,
  input  logic [31:0]               i_addr,
  output logic                      i_addr_ok,
  output logic                      i_data_ok,
  output logic [31:0]               i_rdata,
  input  logic                      i_cancel,
  input  logic                      d_req,
  input  logic                      d_wr,
  input  logic [1:0]                d_size,
  input  logic [31:0]               d_addr,
  input  logic [3:0]                d_wstrb,
  input  logic [31:0]               d_wdata,
  output logic                      d_addr_ok,
  output logic                      d_data_ok,
  output logic [31:0]               d_rdata,
  output logic                      s_req,
  output logic                      s_wr,
  output logic [1:0]                s_size,
  output logic [31:0]               s_addr,
  output logic [3:0]                s_wstrb,
  output logic [31:0]               s_wdata,
  input  logic                      s_addr_ok,
  input  logic                      s_data_ok,
  input  logic [31:0]               s_rdata,
  output logic [$clog2(OT_DEPTH):0] ot_cnt,
  output logic                      resp_err
);

  master_id_t   grant;
  master_id_t   lock_id;
  logic         lock_valid;
  logic         grant_req;
  logic         present;
  logic         accept;
  logic         pop;
  logic         fifo_empty;
  logic         fifo_full;
  order_entry_t head;
  order_entry_t push_entry;

`ifdef ARB_ROUND_ROBIN_EN
  master_id_t last_id;

  // Remember who was accepted last so a contested grant goes to the other side.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_id <= ID_I;
    end else if (accept) begin
      last_id <= grant;
    end
  end
`endif

  // Pick the requester that owns the slave port this cycle.
  always_comb begin
    grant = ID_D;
    if (lock_valid) begin
      grant = lock_id;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (d_req && i_req) begin
        grant = (last_id == ID_I) ? ID_D : ID_I;
      end else if (d_req) begin
        grant = ID_D;
      end else begin
        grant = ID_I;
      end
`else
      if (d_req) begin
        grant = ID_D;
      end else begin
        grant = ID_I;
      end
`endif
    end
  end

  assign grant_req = (grant == ID_D) ? d_req : i_req;
  assign s_req     = resetn & grant_req & ~fifo_full;
  assign present   = resetn & (lock_valid | i_req | d_req);
  assign accept    = s_req & s_addr_ok;
  assign i_addr_ok = accept & (grant == ID_I);
  assign d_addr_ok = accept & (grant == ID_D);

  // Drive the slave payload from the granted requester; fetches are fixed word reads.
  always_comb begin
    s_wr    = 1'b0;
    s_size  = 2'b00;
    s_addr  = 32'h0;
    s_wstrb = 4'h0;
    s_wdata = 32'h0;
    if (present) begin
      if (grant == ID_D) begin
        s_wr    = d_wr;
        s_size  = d_size;
        s_addr  = d_addr;
        s_wstrb = d_wstrb;
        s_wdata = d_wdata;
      end else begin
        s_size  = SIZE_W;
        s_addr  = i_addr;
      end
    end
  end

  // Hold the grant on a presented but unaccepted request so its payload stays stable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_valid <= 1'b0;
      lock_id    <= ID_I;
    end else if (accept) begin
      lock_valid <= 1'b0;
    end else if (s_req) begin
      lock_valid <= 1'b1;
      lock_id    <= grant;
    end
  end

  assign push_entry = '{id: grant, discard: (grant == ID_I) && i_cancel};
  assign pop        = resetn & s_data_ok & ~fifo_empty;

  arb_order_fifo #(
    .DEPTH(OT_DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_entry(push_entry),
    .pop       (pop),
    .cancel_i  (resetn & i_cancel),
    .head      (head),
    .count     (ot_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign i_data_ok = pop & (head.id == ID_I) & ~head.discard & ~i_cancel;
  assign d_data_ok = pop & (head.id == ID_D);
  assign i_rdata   = s_rdata;
  assign d_rdata   = s_rdata;

  // Flag a response that arrives with nothing outstanding; stays set until reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_err <= 1'b0;
    end else if (s_data_ok && fifo_empty) begin
      resp_err <= 1'b1;
    end
  end

endmodule
